// File: rtl/pattern_sequencer_if.sv
// Generator-facing bundle of the pattern sequencer: duration programming in,
// pattern schedule and animation step out.
interface pattern_sequencer_if #(
  parameter int NUM_PATTERNS = 4
);
  logic                    cfg_we;
  logic [1:0]              cfg_idx;
  logic [9:0]              cfg_frames;
  logic [1:0]              pattern_select;
  logic [NUM_PATTERNS-1:0] pattern_enable;
  logic [11:0]             step_size;
  logic                    hold_active;
  logic                    switch_pulse;
  logic [9:0]              frame_count;

  modport master (
    input  cfg_we, cfg_idx, cfg_frames,
    output pattern_select, pattern_enable, step_size, hold_active, switch_pulse, frame_count
  );

  modport slave (
    output cfg_we, cfg_idx, cfg_frames,
    input  pattern_select, pattern_enable, step_size, hold_active, switch_pulse, frame_count
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Chooses the on-screen VGA pattern: frame-counted auto-advance, button control,
// and pattern changes deferred to the frame origin.
module pattern_sequencer #(
  parameter int NUM_PATTERNS   = 4,
  parameter int FRAMES_DEFAULT = 240,
  parameter int STEP_DEFAULT   = 16,
  parameter int STEP_MIN       = 1,
  parameter int STEP_MAX       = 2048
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       vsync,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_hold,
  input  logic       btn_faster,
  input  logic       btn_slower,
  pattern_sequencer_if.master bus
);
  typedef enum logic [1:0] {AUTO, HOLD, PEND} state_t;

  localparam logic [1:0]              LAST       = 2'(NUM_PATTERNS - 1);
  localparam logic [9:0]              FRAMES_RST = 10'(FRAMES_DEFAULT);
  localparam logic [11:0]             STEP_RST   = 12'(STEP_DEFAULT);
  localparam logic [12:0]             STEP_HI    = 13'(STEP_MAX);
  localparam logic [12:0]             STEP_LO    = 13'(STEP_MIN);
  localparam logic [NUM_PATTERNS-1:0] ONE_HOT0   = NUM_PATTERNS'(1);

  state_t      state, state_n, ret, ret_n;
  logic [1:0]  sel, sel_n, target, target_n;
  logic [9:0]  fc, fc_n, eff_m1;
  logic [11:0] step, step_n;
  logic        hold_q, hold_n, pulse_q, pulse_n;
  logic [9:0]  dur [4];
  logic        vsync_q, tick, at_origin;
  logic [4:0]  btn_raw, btn_s1, btn_s2, btn_s3, btn_act;
  logic        do_next, do_prev;
  logic [12:0] step_x2, step_half;

  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return (v == LAST) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] wrap_dec(input logic [1:0] v);
    return (v == 2'd0) ? LAST : v - 2'd1;
  endfunction

  // Bit order {slower, faster, hold, prev, next}; s3 only serves the edge detector.
  assign btn_raw   = {btn_slower, btn_faster, btn_hold, btn_prev, btn_next};
  assign btn_act   = btn_s2 & ~btn_s3;
  assign do_next   = btn_act[0] & ~btn_act[1];
  assign do_prev   = btn_act[1] & ~btn_act[0];
  assign tick      = vsync & ~vsync_q;
  assign at_origin = (x == 10'd0) && (y == 10'd0);
  assign eff_m1    = (dur[sel] == 10'd0) ? 10'd0 : dur[sel] - 10'd1;
  assign step_x2   = {step, 1'b0};
  assign step_half = {2'b00, step[11:1]};

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one unassigned and infer a latch.
    state_n  = state;
    ret_n    = ret;
    target_n = target;
    sel_n    = sel;
    fc_n     = fc;
    step_n   = step;
    pulse_n  = 1'b0;

    case (state)
      AUTO, HOLD: begin
        if (do_next || do_prev) begin
          state_n  = PEND;
          ret_n    = state;
          target_n = do_next ? wrap_inc(sel) : wrap_dec(sel);
        end else if (state == AUTO && tick) begin
          if (fc >= eff_m1) begin
            fc_n     = 10'd0;
            target_n = wrap_inc(sel);
            ret_n    = AUTO;
            state_n  = PEND;
          end else begin
            fc_n = fc + 10'd1;
          end
        end
      end
      PEND: begin
        if (do_next)      target_n = wrap_inc(target);
        else if (do_prev) target_n = wrap_dec(target);
      end
      default: state_n = AUTO;
    endcase

    // Hold acts on whatever the next/prev decision left behind.
    if (btn_act[2]) begin
      if (state_n == PEND) ret_n   = (ret_n == HOLD) ? AUTO : HOLD;
      else                 state_n = (state_n == HOLD) ? AUTO : HOLD;
    end

    // Committing on the decision cycle lets an origin-aligned press land without an extra wait.
    if (state_n == PEND && at_origin) begin
      sel_n   = target_n;
      fc_n    = 10'd0;
      state_n = ret_n;
      pulse_n = 1'b1;
    end

    if (btn_act[3] && !btn_act[4]) begin
      step_n = (step_x2 > STEP_HI) ? STEP_HI[11:0] : step_x2[11:0];
    end else if (btn_act[4] && !btn_act[3]) begin
      step_n = (step_half < STEP_LO) ? STEP_LO[11:0] : step_half[11:0];
    end

    hold_n = (state_n == HOLD) || (state_n == PEND && ret_n == HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= AUTO;
      ret     <= AUTO;
      target  <= 2'd0;
      sel     <= 2'd0;
      fc      <= 10'd0;
      step    <= STEP_RST;
      hold_q  <= 1'b0;
      pulse_q <= 1'b0;
      vsync_q <= 1'b1;
      btn_s1  <= 5'd0;
      btn_s2  <= 5'd0;
      btn_s3  <= 5'd0;
    end else begin
      state   <= state_n;
      ret     <= ret_n;
      target  <= target_n;
      sel     <= sel_n;
      fc      <= fc_n;
      step    <= step_n;
      hold_q  <= hold_n;
      pulse_q <= pulse_n;
      vsync_q <= vsync;
      btn_s1  <= btn_raw;
      btn_s2  <= btn_s1;
      btn_s3  <= btn_s2;
    end
  end

  // NOTE: the duration table is reset because every pattern must start at FRAMES_DEFAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dur[i] <= FRAMES_RST;
    end else if (bus.cfg_we && int'(bus.cfg_idx) < NUM_PATTERNS) begin
      dur[bus.cfg_idx] <= bus.cfg_frames;
    end
  end

  assign bus.pattern_select = sel;
  assign bus.pattern_enable = ONE_HOT0 << sel;
  assign bus.step_size      = step;
  assign bus.hold_active    = hold_q;
  assign bus.switch_pulse   = pulse_q;
  assign bus.frame_count    = fc;
endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboarded bench for pattern_sequencer: a rule-level model predicts every
// commit and the status outputs; a monitor checks each switch_pulse against it.
module tb_pattern_sequencer;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = 10'd5, y = 10'd5;
  logic       vsync = 1'b1;
  logic [4:0] btn = 5'd0;  // {slower, faster, hold, prev, next}

  localparam logic [4:0] B_NEXT = 5'b00001, B_PREV = 5'b00010, B_HOLD = 5'b00100,
                         B_FAST = 5'b01000, B_SLOW = 5'b10000;

  pattern_sequencer_if #(.NUM_PATTERNS(N)) bus ();

  pattern_sequencer #(.NUM_PATTERNS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .vsync      (vsync),
    .btn_next   (btn[0]),
    .btn_prev   (btn[1]),
    .btn_hold   (btn[2]),
    .btn_faster (btn[3]),
    .btn_slower (btn[4]),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_AUTO, M_HOLD, M_PEND} mmode_t;
  typedef struct { int cyc; int sel; bit hold; } commit_t;

  commit_t    exp_q[$];
  logic [4:0] sched [int];
  int         cyc = 0;
  int         m_sel, m_target, m_fc, m_step;
  int         m_dur [N];
  mmode_t     m_mode, m_ret;
  bit         m_vs_prev;
  logic [4:0] m_btn_prev;

  function automatic bit m_hold_now();
    return (m_mode == M_HOLD) || (m_mode == M_PEND && m_ret == M_HOLD);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [4:0] acts, rise;
    bit tick, nx, pv, org;
    int eff;
    if (!rst_n) begin
      m_sel = 0; m_target = 0; m_fc = 0; m_step = 16;
      for (int i = 0; i < N; i++) m_dur[i] = 240;
      m_mode = M_AUTO; m_ret = M_AUTO;
      m_vs_prev = 1'b1; m_btn_prev = 5'd0;
      exp_q.delete();
      sched.delete();
    end else begin
      cyc++;
      // A press acts on the third edge that sees it high.
      acts = sched.exists(cyc) ? sched[cyc] : 5'd0;
      sched.delete(cyc);
      rise = btn & ~m_btn_prev;
      m_btn_prev = btn;
      if (rise != 5'd0) sched[cyc + 2] = (sched.exists(cyc + 2) ? sched[cyc + 2] : 5'd0) | rise;

      tick = vsync && !m_vs_prev;
      m_vs_prev = vsync;
      org = (x == 10'd0) && (y == 10'd0);
      eff = (m_dur[m_sel] == 0) ? 1 : m_dur[m_sel];
      nx = acts[0] && !acts[1];
      pv = acts[1] && !acts[0];

      case (m_mode)
        M_AUTO, M_HOLD: begin
          if (nx || pv) begin
            m_target = (m_sel + (nx ? 1 : N - 1)) % N;
            m_ret = m_mode;
            m_mode = M_PEND;
          end else if (m_mode == M_AUTO && tick) begin
            if (m_fc + 1 >= eff) begin
              m_fc = 0; m_target = (m_sel + 1) % N; m_ret = M_AUTO; m_mode = M_PEND;
            end else begin
              m_fc++;
            end
          end
        end
        default: if (nx || pv) m_target = (m_target + (nx ? 1 : N - 1)) % N;
      endcase

      if (acts[2]) begin
        if (m_mode == M_PEND) m_ret = (m_ret == M_HOLD) ? M_AUTO : M_HOLD;
        else                  m_mode = (m_mode == M_HOLD) ? M_AUTO : M_HOLD;
      end

      if (acts[3] && !acts[4])      m_step = (m_step * 2 > 2048) ? 2048 : m_step * 2;
      else if (acts[4] && !acts[3]) m_step = (m_step / 2 < 1) ? 1 : m_step / 2;

      if (m_mode == M_PEND && org) begin
        m_sel = m_target; m_fc = 0; m_mode = m_ret;
        exp_q.push_back('{cyc: cyc, sel: m_sel, hold: (m_mode == M_HOLD)});
      end

      if (bus.cfg_we && int'(bus.cfg_idx) < N) m_dur[bus.cfg_idx] = int'(bus.cfg_frames);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    commit_t e;
    if (rst_n) begin
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("commit_missed_cycle", 32'(cyc), 32'(e.cyc));
      end
      if (bus.switch_pulse) begin
        if (exp_q.size() == 0) begin
          check("spurious_switch_pulse", 32'(bus.switch_pulse), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("commit_cycle", 32'(cyc), 32'(e.cyc));
          check("commit_select", 32'(bus.pattern_select), 32'(e.sel));
          check("commit_enable", 32'(bus.pattern_enable), 32'd1 << e.sel);
          check("commit_frame_count", 32'(bus.frame_count), 32'd0);
          check("commit_hold", 32'(bus.hold_active), 32'(e.hold));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk); btn = m;
    @(negedge clk); btn = 5'd0;
    cycles(3);
  endtask

  task automatic frame();
    @(negedge clk); vsync = 1'b0;
    @(negedge clk); vsync = 1'b1;
    cycles(1);
  endtask

  task automatic write_dur(input int idx, input int f);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'(idx); bus.cfg_frames = 10'(f);
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic set_origin(input bit o);
    x = o ? 10'd0 : 10'd5;
    y = o ? 10'd0 : 10'd5;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn = 5'd0; vsync = 1'b1; set_origin(1'b0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_select"}, 32'(bus.pattern_select), 32'(m_sel));
    check({tag, "_enable"}, 32'(bus.pattern_enable), 32'd1 << m_sel);
    check({tag, "_frame_count"}, 32'(bus.frame_count), 32'(m_fc));
    check({tag, "_step"}, 32'(bus.step_size), 32'(m_step));
    check({tag, "_hold"}, 32'(bus.hold_active), 32'(m_hold_now()));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_select"}, 32'(bus.pattern_select), 32'd0);
    check({tag, "_enable"}, 32'(bus.pattern_enable), 32'd1);
    check({tag, "_step"}, 32'(bus.step_size), 32'd16);
    check({tag, "_hold"}, 32'(bus.hold_active), 32'd0);
    check({tag, "_pulse"}, 32'(bus.switch_pulse), 32'd0);
    check({tag, "_frame_count"}, 32'(bus.frame_count), 32'd0);
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_idx = 2'd0; bus.cfg_frames = 10'd0;
    cycles(2);
    check_reset_values("reset");
    rst_n = 1'b1;
    cycles(1);

    // Auto expiry after three frames, deferred to the origin.
    write_dur(0, 3);
    repeat (3) frame();
    check("expiry_select_held", 32'(bus.pattern_select), 32'd0);
    check_status("expiry_pending");
    set_origin(1'b1);
    cycles(2);
    check("expiry_commit_select", 32'(bus.pattern_select), 32'd1);
    check_status("expiry_done");
    set_origin(1'b0);

    // prev from pattern 0 wraps; origin-aligned press commits on its third edge.
    do_reset();
    press(B_PREV);
    cycles(5);
    check("prev_deferred_select", 32'(bus.pattern_select), 32'd0);
    set_origin(1'b1);
    cycles(2);
    check("prev_wrap_select", 32'(bus.pattern_select), 32'd3);
    @(negedge clk); btn = B_NEXT;
    @(negedge clk); btn = 5'd0;
    check("press_edge1_pulse", 32'(bus.switch_pulse), 32'd0);
    @(negedge clk);
    check("press_edge2_pulse", 32'(bus.switch_pulse), 32'd0);
    @(negedge clk);
    check("press_edge3_pulse", 32'(bus.switch_pulse), 32'd1);
    check("next_wrap_select", 32'(bus.pattern_select), 32'd0);
    cycles(2);
    set_origin(1'b0);

    // Hold freezes the frame count through 500 frames, then resumes.
    do_reset();
    repeat (5) frame();
    press(B_HOLD);
    check("hold_on", 32'(bus.hold_active), 32'd1);
    repeat (500) frame();
    check("hold_frozen_count", 32'(bus.frame_count), 32'd5);
    check_status("hold_frozen");
    press(B_HOLD);
    repeat (2) frame();
    check("hold_resume_count", 32'(bus.frame_count), 32'd7);
    check_status("hold_resumed");

    // Step saturation in both directions and the cancelling combination.
    do_reset();
    repeat (8) press(B_FAST);
    check("step_max", 32'(bus.step_size), 32'd2048);
    press(B_FAST);
    check("step_max_sat", 32'(bus.step_size), 32'd2048);
    repeat (12) press(B_SLOW);
    check("step_min_sat", 32'(bus.step_size), 32'd1);
    press(B_FAST);
    press(B_FAST | B_SLOW);
    check("step_both_cancel", 32'(bus.step_size), 32'd2);

    // Double re-target while pending, then next+prev cancelling.
    do_reset();
    set_origin(1'b1);
    press(B_NEXT);
    check("retarget_start_select", 32'(bus.pattern_select), 32'd1);
    set_origin(1'b0);
    press(B_NEXT);
    press(B_NEXT);
    check_status("retarget_pending");
    set_origin(1'b1);
    cycles(2);
    check("retarget_commit_select", 32'(bus.pattern_select), 32'd3);
    set_origin(1'b0);
    press(B_NEXT | B_PREV);
    set_origin(1'b1);
    cycles(5);
    check("cancel_select", 32'(bus.pattern_select), 32'd3);
    set_origin(1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < N; i++) write_dur(i, int'($urandom_range(0, 6)));
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 100 == 99) check_status("random");
      if ($urandom_range(0, 2) == 0) vsync = ~vsync;
      x = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 799));
      y = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 524));
      btn = ($urandom_range(0, 14) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      bus.cfg_we = ($urandom_range(0, 59) == 0);
      bus.cfg_idx = 2'($urandom_range(0, 3));
      bus.cfg_frames = 10'($urandom_range(0, 6));
    end
    @(negedge clk);
    btn = 5'd0; bus.cfg_we = 1'b0; vsync = 1'b1; set_origin(1'b0);
    cycles(4);
    check_status("random_end");

    // Asynchronous reset in the middle of a pending switch.
    do_reset();
    write_dur(0, 200);
    repeat (100) frame();
    press(B_NEXT);
    cycles(2);
    check("pend_frame_count", 32'(bus.frame_count), 32'd100);
    check_status("pend_before_reset");
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    set_origin(1'b1);
    cycles(20);
    check("after_reset_select", 32'(bus.pattern_select), 32'd0);
    set_origin(1'b0);
    cycles(2);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
